// File: rtl/sin_meas_pkg.sv
// Shared types and the golden quantizer for the sine sink measurement block.
package sin_meas_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;
  typedef enum logic [1:0] {UNKNOWN, POS, NEG} pol_t;

  function automatic real clamp_v(real x, real vref);
    if (x > vref) return vref;
    if (x < -vref) return -vref;
    return x;
  endfunction

  // Symmetric code range: full scale maps to +/-(2^(nbits-1)-1), never the most negative code.
  function automatic int quantize(real x, real vref, int unsigned nbits);
    real fs;
    real r;
    fs = real'((32'd1 << (nbits - 32'd1)) - 32'd1);
    r  = clamp_v(x, vref) / vref * fs;
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

endpackage

// File: rtl/sin_quant.sv
// Clamp, round and register the real-valued input into a signed ADC code.
module sin_quant
  import sin_meas_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter real         VREF   = 1.0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  real                      in_sine,
  output logic signed [N_BITS-1:0] code
);

  always_ff @(posedge clk) begin
    if (rst) code <= '0;
    else     code <= N_BITS'(quantize(in_sine, VREF, N_BITS));
  end

endmodule

// File: rtl/sin_sink_meas.sv
// Sine sink: quantizes the input and measures mean period and amplitude over N_PERIODS rising crossings.
module sin_sink_meas
  import sin_meas_pkg::*;
#(
  parameter int unsigned N_BITS    = 8,
  parameter real         VREF      = 1.0,
  parameter real         HYST      = 0.05,
  parameter int unsigned N_PERIODS = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  real                      in_sine,
  output logic signed [N_BITS-1:0] adc_code,
  output logic                     zc_rise,
  output logic [CNT_W-1:0]         period_cyc,
  output logic signed [N_BITS-1:0] amp_code,
  output logic                     meas_valid,
  input  logic                     meas_ready,
  output logic                     overrun,
  output logic                     timeout
);

  localparam int unsigned LOG2_NP = $clog2(N_PERIODS);
  localparam int unsigned ACC_W   = CNT_W + LOG2_NP;
  localparam int unsigned PER_W   = (N_PERIODS > 1) ? LOG2_NP : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(N_PERIODS - 1);

  state_t                   state_q, state_d;
  pol_t                     pol_q;
  real                      x_c;
  logic [CNT_W-1:0]         cyc_cnt_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_sum_c;
  logic [PER_W-1:0]         per_cnt_q;
  logic signed [N_BITS-1:0] min_q, max_q, min_c, max_c;
  logic signed [N_BITS:0]   span_c;
  logic                     start_c, complete_c, sat_c;

  sin_quant #(.N_BITS(N_BITS), .VREF(VREF)) u_quant (
    .clk     (clk),
    .rst     (rst),
    .in_sine (in_sine),
    .code    (adc_code)
  );

  // Hysteretic polarity tracker; runs regardless of en so crossings are never missed.
  always_comb x_c = clamp_v(in_sine, VREF);

  always_ff @(posedge clk) begin
    if (rst) begin
      pol_q   <= UNKNOWN;
      zc_rise <= 1'b0;
    end else begin
      zc_rise <= 1'b0;
      if (x_c > HYST) begin
        if (pol_q == NEG) zc_rise <= 1'b1;
        pol_q <= POS;
      end else if (x_c < -HYST) begin
        pol_q <= NEG;
      end
    end
  end

  always_comb begin
    min_c      = (adc_code < min_q) ? adc_code : min_q;
    max_c      = (adc_code > max_q) ? adc_code : max_q;
    acc_sum_c  = acc_q + ACC_W'(cyc_cnt_q);
    span_c     = (N_BITS+1)'(max_c) - (N_BITS+1)'(min_c);
    start_c    = (state_q == S_ARM) && zc_rise;
    complete_c = (state_q == S_MEAS) && zc_rise && (per_cnt_q == PER_LAST);
    sat_c      = (state_q == S_MEAS) && !zc_rise && (cyc_cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_ARM;
      S_ARM:   if (zc_rise) state_d = S_MEAS;
      S_MEAS:  if (sat_c) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
    if (!en) state_d = S_IDLE;
  end

  // Window counters; the closing crossing immediately opens the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      acc_q     <= '0;
      per_cnt_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else if (start_c || complete_c) begin
      cyc_cnt_q <= CNT_W'(1);
      acc_q     <= '0;
      per_cnt_q <= '0;
      min_q     <= adc_code;
      max_q     <= adc_code;
    end else if (state_q == S_MEAS) begin
      min_q <= min_c;
      max_q <= max_c;
      if (zc_rise) begin
        acc_q     <= acc_sum_c;
        cyc_cnt_q <= CNT_W'(1);
        per_cnt_q <= per_cnt_q + 1'b1;
      end else if (cyc_cnt_q != CNT_MAX) begin
        cyc_cnt_q <= cyc_cnt_q + 1'b1;
      end
    end
  end

  // Result register and valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cyc <= '0;
      amp_code   <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (sat_c) timeout <= 1'b1;
      if (complete_c) begin
        period_cyc <= CNT_W'(acc_sum_c >> LOG2_NP);
        amp_code   <= N_BITS'(span_c >>> 1);
        meas_valid <= 1'b1;
        if (meas_valid && !meas_ready) overrun <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sin_sink_meas.sv
// Scoreboard bench for sin_sink_meas: sine, clipping, noise, backpressure, reset and timeout scenarios.
module tb_sin_sink_meas;
  import sin_meas_pkg::*;

  localparam int unsigned N_BITS    = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned N_PERIODS = 4;
  localparam real         VREF      = 1.0;
  localparam real         HYST      = 0.05;
  localparam int          TMO       = 256;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     en = 1'b0;
  logic                     meas_ready = 1'b1;
  real                      in_sine = 0.0;
  logic signed [N_BITS-1:0] adc_code;
  logic                     zc_rise;
  logic [CNT_W-1:0]         period_cyc;
  logic signed [N_BITS-1:0] amp_code;
  logic                     meas_valid;
  logic                     overrun;
  logic                     timeout;

  sin_sink_meas #(
    .N_BITS(N_BITS), .VREF(VREF), .HYST(HYST), .N_PERIODS(N_PERIODS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_sine(in_sine), .adc_code(adc_code),
    .zc_rise(zc_rise), .period_cyc(period_cyc), .amp_code(amp_code),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int amp;
    int t_valid;
  } res_t;

  res_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   n_s = 0;
  int   n_res = 0;
  int   last_period = -1;
  int   last_amp = -1;
  int   exp_code = 0;
  bit   exp_zc = 1'b0;
  bit   exp_ovr = 1'b0;
  bit   exp_tmo = 1'b0;
  pol_t m_pol = UNKNOWN;
  bit   m_meas = 1'b0;
  int   m_t0, m_tlast, m_n, m_lo, m_hi;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic real sine_at(real amp, int n);
    return amp * $sin(2.0 * 3.141592653589793 * (real'(n) + 0.3) / 20.0);
  endfunction

  // Compare every registered output against the model for the cycle just after a posedge.
  task automatic check_cycle();
    bit ev;
    check("adc_code", adc_code, exp_code);
    check("zc_rise", zc_rise, exp_zc);
    check("no_minus_fs", adc_code == -8'sd128, 0);
    while (sb_q.size() > 1 && sb_q[1].t_valid <= cyc) begin
      void'(sb_q.pop_front());
      exp_ovr = 1'b1;
    end
    ev = (sb_q.size() > 0) && (sb_q[0].t_valid <= cyc);
    check("meas_valid", meas_valid, ev);
    if (ev) begin
      check("period_cyc", period_cyc, sb_q[0].period);
      check("amp_code", amp_code, sb_q[0].amp);
      last_period = int'(period_cyc);
      last_amp    = int'(amp_code);
    end
    check("overrun", overrun, exp_ovr);
    check("timeout", timeout, exp_tmo);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
  endtask

  // Drive one sample for the next edge and advance the reference model in crossing-timestamp terms.
  task automatic drive(input real x, input bit en_v, input bit rst_v, input bit rdy);
    int  t;
    int  code;
    real xc;
    bit  zc;
    t = cyc + 1;
    in_sine = x;
    en = en_v;
    rst = rst_v;
    meas_ready = rdy;
    if (!rst_v && sb_q.size() > 0 && sb_q[0].t_valid <= cyc && rdy) begin
      void'(sb_q.pop_front());
      n_res++;
    end
    xc   = clamp_v(x, VREF);
    code = quantize(x, VREF, N_BITS);
    zc   = 1'b0;
    if (rst_v) begin
      m_pol = UNKNOWN; m_meas = 1'b0; sb_q.delete();
      exp_ovr = 1'b0; exp_tmo = 1'b0; exp_code = 0; exp_zc = 1'b0;
    end else begin
      if (xc > HYST) begin
        zc = (m_pol == NEG);
        m_pol = POS;
      end else if (xc < -HYST) begin
        m_pol = NEG;
      end
      exp_code = code;
      exp_zc = zc;
      if (!en_v) begin
        m_meas = 1'b0;
      end else begin
        if (m_meas && (t - m_tlast) >= TMO) begin
          m_meas = 1'b0;
          exp_tmo = 1'b1;
        end
        if (m_meas) begin
          if (code < m_lo) m_lo = code;
          if (code > m_hi) m_hi = code;
        end
        if (zc) begin
          if (m_meas) begin
            m_n++;
            if (m_n == N_PERIODS) begin
              sb_q.push_back('{period: (t - m_t0) / N_PERIODS, amp: (m_hi - m_lo) / 2, t_valid: t + 1});
              m_t0 = t; m_n = 0; m_lo = code; m_hi = code;
            end
          end else begin
            m_meas = 1'b1; m_t0 = t; m_n = 0; m_lo = code; m_hi = code;
          end
          m_tlast = t;
        end
      end
    end
    tick();
  endtask

  initial begin
    real x;
    int  lo, hi, nzc;

    // Power-on reset.
    for (int i = 0; i < 3; i++) drive(0.0, 1'b0, 1'b1, 1'b1);
    check("rst_period", period_cyc, 0);
    check("rst_amp", amp_code, 0);

    // Unit sine, period 20, always ready.
    for (int i = 0; i < 200; i++) begin
      x = sine_at(1.0, n_s); n_s++;
      drive(x, 1'b1, 1'b0, 1'b1);
    end
    check("sine_nres", n_res >= 2, 1);
    check("sine_period", last_period, 20);
    check("sine_amp", (last_amp >= 126) && (last_amp <= 128), 1);

    // Backpressure across two windows, then drain.
    for (int i = 0; i < 200; i++) begin
      x = sine_at(1.0, n_s); n_s++;
      drive(x, 1'b1, 1'b0, 1'b0);
    end
    check("bp_overrun", overrun, 1);
    check("bp_held", meas_valid, 1);
    for (int i = 0; i < 40; i++) begin
      x = sine_at(1.0, n_s); n_s++;
      drive(x, 1'b1, 1'b0, 1'b1);
    end

    // Reset in the middle of a live stream.
    for (int i = 0; i < 3; i++) begin
      x = sine_at(1.0, n_s); n_s++;
      drive(x, 1'b0, 1'b1, 1'b1);
    end
    check("mid_rst_period", period_cyc, 0);
    check("mid_rst_amp", amp_code, 0);
    check("mid_rst_overrun", overrun, 0);

    // Over-range sine clips symmetrically.
    lo = 0; hi = 0;
    for (int i = 0; i < 200; i++) begin
      x = sine_at(2.0, n_s); n_s++;
      drive(x, 1'b1, 1'b0, 1'b1);
      if (int'(adc_code) < lo) lo = int'(adc_code);
      if (int'(adc_code) > hi) hi = int'(adc_code);
    end
    check("clip_hi", hi, 127);
    check("clip_lo", lo, -127);
    check("clip_amp", last_amp, 127);

    // Sub-hysteresis noise after re-arming: no crossings, no results.
    nzc = 0;
    for (int i = 0; i < 302; i++) begin
      x = real'(int'($urandom_range(600, 0)) - 300) / 10000.0;
      drive(x, i >= 2, 1'b0, 1'b1);
      nzc += int'(zc_rise);
    end
    check("noise_zc", nzc, 0);
    check("noise_valid", meas_valid, 0);
    check("noise_timeout", timeout, 0);

    // Single crossing into DC: period counter saturates.
    for (int i = 0; i < 10; i++) drive(-0.5, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) drive(0.5, 1'b1, 1'b0, 1'b1);
    check("dc_timeout", timeout, 1);
    check("dc_valid", meas_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
